// File: rtl/ser_pkg.sv
// ser_pkg: shared types and constants for the delay_search_ser block.
//   ser_state_e     - sweep/lock controller states
//   DELAY_W         - width of the delay_chain select
//   NUM_DELAYS      - number of delay settings swept
//   ERR_INIT_ONES   - all-ones seed for best_err_count (truncate to CNT_W)
package ser_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, EVAL} ser_state_e;

    localparam int unsigned DELAY_W    = 4;
    localparam int unsigned NUM_DELAYS = 16;

    localparam logic [31:0] ERR_INIT_ONES = '1;

endpackage

// File: rtl/delay_search_ser_if.sv
// delay_search_ser_if: bundles the symbol inputs, control and status of delay_search_ser.
//   slave  - the delay search block (consumes symbols/start, drives delay and status)
//   master - the upstream/controlling side
interface delay_search_ser_if
    import ser_pkg::*;
#(
    parameter int unsigned CNT_W = 11
) ();

    logic               sym_clk_ena;
    logic               start;
    logic               sym_correct;
    logic               sym_error;
    logic [DELAY_W-1:0] delay_chain;
    logic               busy;
    logic               locked;
    logic [DELAY_W-1:0] best_delay;
    logic [CNT_W-1:0]   best_err_count;
    logic [CNT_W-1:0]   err_count;
    logic [CNT_W-1:0]   sym_count;
    logic               window_done;
    ser_state_e         state;

    modport slave (
        input  sym_clk_ena, start, sym_correct, sym_error,
        output delay_chain, busy, locked, best_delay, best_err_count,
               err_count, sym_count, window_done, state
    );

    modport master (
        output sym_clk_ena, start, sym_correct, sym_error,
        input  delay_chain, busy, locked, best_delay, best_err_count,
               err_count, sym_count, window_done, state
    );

endinterface

// File: rtl/ser_window_counter.sv
// ser_window_counter: shared symbol/error counter.
//   sys_clk, reset   - clock, async active-high reset
//   clr_i            - synchronous clear (wins over en_i)
//   en_i             - count one tick/symbol this cycle
//   err_i            - current symbol is an error (ignored in settle mode)
//   settle_mode_i    - 1: count settle ticks up to SETTLE_LEN, 0: window up to WINDOW_LEN
//   sym_next_o       - symbol count including this cycle's increment
//   err_next_o       - error count including this cycle's increment
//   tc_o             - this cycle's increment reaches the terminal count
module ser_window_counter #(
    parameter int unsigned WINDOW_LEN = 1024,
    parameter int unsigned SETTLE_LEN = 32,
    parameter int unsigned CNT_W      = 11
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             err_i,
    input  logic             settle_mode_i,
    output logic [CNT_W-1:0] sym_next_o,
    output logic [CNT_W-1:0] err_next_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] WindowLast = CNT_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_LEN - 1);

    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] last_val;

    always_comb begin
        last_val   = settle_mode_i ? SettleLast : WindowLast;
        tc_o       = en_i && (sym_cnt_q == last_val);
        sym_next_o = en_i ? sym_cnt_q + 1'b1 : sym_cnt_q;
        err_next_o = (en_i && err_i && !settle_mode_i) ? err_cnt_q + 1'b1 : err_cnt_q;
        sym_cnt_d  = clr_i ? '0 : sym_next_o;
        err_cnt_d  = clr_i ? '0 : err_next_o;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sym_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: rtl/delay_search_ser.sv
// delay_search_ser: sweeps all delay_chain settings of symbol_comparison, measures symbol
// errors over a fixed window at each, locks on the delay with fewest errors (lowest delay
// wins ties) and then keeps reporting the per-window error count.
//   sys_clk, reset - only clock, async active-high reset back to IDLE
//   bus_io (slave) - sym_clk_ena/start/sym_correct/sym_error in; delay_chain, busy, locked,
//                    best_delay, best_err_count, err_count, sym_count, window_done, state out
module delay_search_ser
    import ser_pkg::*;
#(
    parameter int unsigned WINDOW_LEN = 1024,
    parameter int unsigned SETTLE_LEN = 32,
    parameter int unsigned CNT_W      = 11
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    delay_search_ser_if.slave      bus_io
);

    localparam logic [CNT_W-1:0]   BestErrInit = CNT_W'(ERR_INIT_ONES);
    localparam logic [DELAY_W-1:0] LastDelay   = DELAY_W'(NUM_DELAYS - 1);

    ser_state_e         state_q;
    logic [DELAY_W-1:0] delay_chain_q;
    logic               busy_q;
    logic               locked_q;
    logic [DELAY_W-1:0] best_delay_q;
    logic [CNT_W-1:0]   best_err_count_q;
    logic [CNT_W-1:0]   err_count_q;
    logic [CNT_W-1:0]   sym_count_q;
    logic               window_done_q;

    logic               cnt_clr;
    logic               cnt_en;
    logic               settle_mode;
    logic [CNT_W-1:0]   sym_next;
    logic [CNT_W-1:0]   err_next;
    logic               cnt_tc;
    logic               better;

    // One counter serves both phases: settle ticks in SETTLE, symbols/errors in MEASURE.
    always_comb begin
        cnt_clr     = 1'b1;
        cnt_en      = 1'b0;
        settle_mode = 1'b0;
        case (state_q)
            SETTLE: begin
                cnt_clr     = 1'b0;
                cnt_en      = bus_io.sym_clk_ena;
                settle_mode = 1'b1;
            end
            MEASURE: begin
                cnt_clr = 1'b0;
                cnt_en  = bus_io.sym_clk_ena & (bus_io.sym_correct | bus_io.sym_error);
            end
            default: ;
        endcase
        // Leaving SETTLE starts the window from zero.
        if (state_q == SETTLE && cnt_tc) begin
            cnt_clr = 1'b1;
        end
        // A restart throws away any partial count.
        if (bus_io.start) begin
            cnt_clr = 1'b1;
            cnt_en  = 1'b0;
        end
    end

    ser_window_counter #(
        .WINDOW_LEN (WINDOW_LEN),
        .SETTLE_LEN (SETTLE_LEN),
        .CNT_W      (CNT_W)
    ) u_counter (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .clr_i         (cnt_clr),
        .en_i          (cnt_en),
        .err_i         (bus_io.sym_error),
        .settle_mode_i (settle_mode),
        .sym_next_o    (sym_next),
        .err_next_o    (err_next),
        .tc_o          (cnt_tc)
    );

    // err_count_q already holds the window just finished while in EVAL.
    assign better = (err_count_q < best_err_count_q);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            delay_chain_q    <= '0;
            busy_q           <= 1'b0;
            locked_q         <= 1'b0;
            best_delay_q     <= '0;
            best_err_count_q <= BestErrInit;
            err_count_q      <= '0;
            sym_count_q      <= '0;
            window_done_q    <= 1'b0;
        end else begin
            window_done_q <= 1'b0;
            if (bus_io.start) begin
                state_q          <= SETTLE;
                delay_chain_q    <= '0;
                busy_q           <= 1'b1;
                locked_q         <= 1'b0;
                best_delay_q     <= '0;
                best_err_count_q <= BestErrInit;
            end else begin
                case (state_q)
                    IDLE: ;
                    SETTLE: begin
                        if (cnt_tc) begin
                            state_q <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (cnt_tc) begin
                            err_count_q   <= err_next;
                            sym_count_q   <= sym_next;
                            window_done_q <= 1'b1;
                            state_q       <= EVAL;
                        end
                    end
                    EVAL: begin
                        if (locked_q) begin
                            state_q <= MEASURE;
                        end else begin
                            if (better) begin
                                best_err_count_q <= err_count_q;
                                best_delay_q     <= delay_chain_q;
                            end
                            if (delay_chain_q != LastDelay) begin
                                delay_chain_q <= delay_chain_q + 4'd1;
                            end else begin
                                // Last delay may itself be the new best.
                                delay_chain_q <= better ? delay_chain_q : best_delay_q;
                                locked_q      <= 1'b1;
                            end
                            state_q <= SETTLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus_io.delay_chain    = delay_chain_q;
    assign bus_io.busy           = busy_q;
    assign bus_io.locked         = locked_q;
    assign bus_io.best_delay     = best_delay_q;
    assign bus_io.best_err_count = best_err_count_q;
    assign bus_io.err_count      = err_count_q;
    assign bus_io.sym_count      = sym_count_q;
    assign bus_io.window_done    = window_done_q;
    assign bus_io.state          = state_q;

endmodule

// File: tb/tb_delay_search_ser.sv
// Directed bench for delay_search_ser with WINDOW_LEN=8, SETTLE_LEN=2, CNT_W=4.
// A symbol source emits per-delay periodic error patterns (period 8 over valid symbols), so
// any full window at a given delay carries exactly popcount(pattern) errors.
module tb_delay_search_ser;
    import ser_pkg::*;

    localparam int unsigned WL = 8;
    localparam int unsigned SL = 2;
    localparam int unsigned CW = 4;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    delay_search_ser_if #(.CNT_W(CW)) bus ();

    delay_search_ser #(
        .WINDOW_LEN (WL),
        .SETTLE_LEN (SL),
        .CNT_W      (CW)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus_io  (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Symbol source controls
    bit         drv_on     = 1'b0;
    int         ena_div    = 1;
    int         null_every = 0;
    bit         both_once  = 1'b0;
    logic [7:0] pat [16];
    int         valid_cnt  = 0;

    initial begin
        int cyc;
        int ena_cnt;
        int idx;
        logic [7:0] p;
        cyc = 0; ena_cnt = 0; idx = 0;
        bus.sym_clk_ena = 1'b0;
        bus.sym_correct = 1'b0;
        bus.sym_error   = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            bus.sym_clk_ena = 1'b0;
            bus.sym_correct = 1'b0;
            bus.sym_error   = 1'b0;
            if (drv_on && (cyc % ena_div == 0)) begin
                bus.sym_clk_ena = 1'b1;
                ena_cnt++;
                if (!(null_every != 0 && ena_cnt % null_every == 0)) begin
                    p = pat[bus.delay_chain];
                    bus.sym_correct = 1'b1;
                    bus.sym_error   = p[idx % 8];
                    if (both_once) begin
                        bus.sym_error = 1'b1;
                        both_once     = 1'b0;
                    end
                    idx++;
                    valid_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic set_pat(input logic [7:0] all, input int d0, input logic [7:0] v0,
                           input int d1, input logic [7:0] v1);
        for (int i = 0; i < 16; i++) pat[i] = all;
        pat[d0] = v0;
        pat[d1] = v1;
    endtask

    // Waits (bounded) for the next window_done pulse.
    task automatic wait_wd(input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            tick();
            if (bus.window_done) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: window_done timeout got 0 want 1", name);
        end
    endtask

    task automatic test_reset();
        bit seen;
        reset = 1'b1;
        bus.start = 1'b0;
        drv_on = 1'b0;
        repeat (3) tick();
        n_tests++; if (bus.delay_chain !== 4'd0) begin n_fail++; $display("FAIL rst_delay: got %0d want 0", bus.delay_chain); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %0b want 0", bus.locked); end
        n_tests++; if (bus.best_delay !== 4'd0) begin n_fail++; $display("FAIL rst_best_delay: got %0d want 0", bus.best_delay); end
        n_tests++; if (bus.best_err_count !== 4'hF) begin n_fail++; $display("FAIL rst_best_err: got %0h want f", bus.best_err_count); end
        n_tests++; if (bus.err_count !== 4'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", bus.err_count); end
        n_tests++; if (bus.sym_count !== 4'd0) begin n_fail++; $display("FAIL rst_sym: got %0d want 0", bus.sym_count); end
        n_tests++; if (bus.window_done !== 1'b0) begin n_fail++; $display("FAIL rst_wd: got %0b want 0", bus.window_done); end
        n_tests++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", bus.state, IDLE); end
        reset = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (bus.busy !== 1'b0) seen = 1'b1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL idle_busy: got 1 want 0 over 100 cycles"); end
    endtask

    task automatic test_sweep();
        int wd;
        bit done;
        bit ok;
        logic [3:0] exp_err;
        set_pat(8'hFF, 5, 8'h00, 5, 8'h00);
        ena_div = 1; null_every = 0; drv_on = 1'b1;
        pulse_start();
        n_tests++; if (bus.state !== SETTLE) begin n_fail++; $display("FAIL sweep_start_state: got %0d want %0d", bus.state, SETTLE); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL sweep_busy: got %0b want 1", bus.busy); end
        wd = 0; done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            tick();
            if (bus.window_done) begin
                exp_err = (wd == 5) ? 4'd0 : 4'd8;
                n_tests++;
                if (bus.err_count !== exp_err || bus.delay_chain !== 4'(wd)) begin
                    n_fail++;
                    $display("FAIL sweep_win%0d: got err %0d delay %0d want err %0d delay %0d",
                             wd, bus.err_count, bus.delay_chain, exp_err, wd);
                end
                wd++;
            end
            if (bus.locked) done = 1'b1;
        end
        n_tests++; if (!done) begin n_fail++; $display("FAIL sweep_lock: got unlocked want locked"); end
        n_tests++; if (wd !== 16) begin n_fail++; $display("FAIL sweep_windows: got %0d want 16", wd); end
        n_tests++; if (bus.best_delay !== 4'd5) begin n_fail++; $display("FAIL sweep_best_delay: got %0d want 5", bus.best_delay); end
        n_tests++; if (bus.best_err_count !== 4'd0) begin n_fail++; $display("FAIL sweep_best_err: got %0d want 0", bus.best_err_count); end
        n_tests++; if (bus.delay_chain !== 4'd5) begin n_fail++; $display("FAIL sweep_delay: got %0d want 5", bus.delay_chain); end
        n_tests++; if (bus.state !== SETTLE) begin n_fail++; $display("FAIL sweep_lock_state: got %0d want %0d", bus.state, SETTLE); end
        wait_wd("locked_win", ok);
        if (ok) begin
            n_tests++; if (bus.err_count !== 4'd0) begin n_fail++; $display("FAIL locked_err: got %0d want 0", bus.err_count); end
            n_tests++; if (bus.sym_count !== 4'd8) begin n_fail++; $display("FAIL locked_sym: got %0d want 8", bus.sym_count); end
            n_tests++; if (bus.state !== EVAL) begin n_fail++; $display("FAIL wd_in_eval: got %0d want %0d", bus.state, EVAL); end
            tick();
            n_tests++; if (bus.window_done !== 1'b0) begin n_fail++; $display("FAIL wd_width: got %0b want 0", bus.window_done); end
            n_tests++; if (bus.state !== MEASURE) begin n_fail++; $display("FAIL locked_no_settle: got %0d want %0d", bus.state, MEASURE); end
            n_tests++; if (bus.delay_chain !== 4'd5) begin n_fail++; $display("FAIL locked_delay: got %0d want 5", bus.delay_chain); end
        end
    endtask

    task automatic test_tie();
        bit done;
        set_pat(8'h1F, 3, 8'h03, 9, 8'h03);
        pulse_start();
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            tick();
            if (bus.locked) done = 1'b1;
        end
        n_tests++; if (!done) begin n_fail++; $display("FAIL tie_lock: got unlocked want locked"); end
        n_tests++; if (bus.best_delay !== 4'd3) begin n_fail++; $display("FAIL tie_best_delay: got %0d want 3", bus.best_delay); end
        n_tests++; if (bus.best_err_count !== 4'd2) begin n_fail++; $display("FAIL tie_best_err: got %0d want 2", bus.best_err_count); end
        n_tests++; if (bus.delay_chain !== 4'd3) begin n_fail++; $display("FAIL tie_delay: got %0d want 3", bus.delay_chain); end
    endtask

    task automatic test_abort();
        bit found;
        set_pat(8'hFF, 0, 8'hFF, 0, 8'hFF);
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            tick();
            if (bus.state == MEASURE && bus.delay_chain == 4'd7) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL abort_reach: got no MEASURE@7 want MEASURE@7"); end
        repeat (2) tick();
        pulse_start();
        n_tests++; if (bus.state !== SETTLE) begin n_fail++; $display("FAIL abort_state: got %0d want %0d", bus.state, SETTLE); end
        n_tests++; if (bus.delay_chain !== 4'd0) begin n_fail++; $display("FAIL abort_delay: got %0d want 0", bus.delay_chain); end
        n_tests++; if (bus.best_err_count !== 4'hF) begin n_fail++; $display("FAIL abort_best_err: got %0h want f", bus.best_err_count); end
        n_tests++; if (bus.best_delay !== 4'd0) begin n_fail++; $display("FAIL abort_best_delay: got %0d want 0", bus.best_delay); end
        n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL abort_locked: got %0b want 0", bus.locked); end
        n_tests++; if (bus.err_count !== 4'd8) begin n_fail++; $display("FAIL abort_err_kept: got %0d want 8", bus.err_count); end
        n_tests++; if (bus.sym_count !== 4'd8) begin n_fail++; $display("FAIL abort_sym_kept: got %0d want 8", bus.sym_count); end
    endtask

    task automatic test_locked_errors();
        bit done;
        bit ok;
        int vprev;
        set_pat(8'hFF, 5, 8'h00, 5, 8'h00);
        ena_div = 1;
        pulse_start();
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            tick();
            if (bus.locked) done = 1'b1;
        end
        n_tests++; if (!done) begin n_fail++; $display("FAIL lockerr_lock: got unlocked want locked"); end
        ena_div = 4;
        pat[5] = 8'h49;
        wait_wd("lockerr_discard", ok);
        vprev = valid_cnt;
        for (int k = 0; k < 3; k++) begin
            wait_wd("lockerr_win", ok);
            if (ok) begin
                n_tests++; if (bus.err_count !== 4'd3) begin n_fail++; $display("FAIL lockerr_err%0d: got %0d want 3", k, bus.err_count); end
                n_tests++; if (bus.sym_count !== 4'd8) begin n_fail++; $display("FAIL lockerr_sym%0d: got %0d want 8", k, bus.sym_count); end
                n_tests++; if (valid_cnt - vprev !== 8) begin n_fail++; $display("FAIL lockerr_span%0d: got %0d want 8", k, valid_cnt - vprev); end
            end
            vprev = valid_cnt;
        end
    endtask

    task automatic test_gaps_and_reset();
        bit ok;
        int vprev;
        null_every = 3;
        pat[5] = 8'h00;
        wait_wd("gap_discard", ok);
        wait_wd("gap_clean", ok);
        vprev = valid_cnt;
        if (ok) begin
            n_tests++; if (bus.err_count !== 4'd0) begin n_fail++; $display("FAIL gap_err: got %0d want 0", bus.err_count); end
        end
        both_once = 1'b1;
        wait_wd("gap_both", ok);
        if (ok) begin
            n_tests++; if (bus.err_count !== 4'd1) begin n_fail++; $display("FAIL both_high_err: got %0d want 1", bus.err_count); end
            n_tests++; if (bus.sym_count !== 4'd8) begin n_fail++; $display("FAIL gap_sym: got %0d want 8", bus.sym_count); end
            n_tests++; if (valid_cnt - vprev !== 8) begin n_fail++; $display("FAIL gap_span: got %0d want 8", valid_cnt - vprev); end
        end
        repeat (9) tick();
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL async_state: got %0d want %0d", bus.state, IDLE); end
        n_tests++; if (bus.locked !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_flags: got locked %0b busy %0b want 0 0", bus.locked, bus.busy); end
        n_tests++; if (bus.delay_chain !== 4'd0 || bus.best_delay !== 4'd0) begin n_fail++; $display("FAIL async_delay: got %0d/%0d want 0/0", bus.delay_chain, bus.best_delay); end
        n_tests++; if (bus.err_count !== 4'd0 || bus.sym_count !== 4'd0) begin n_fail++; $display("FAIL async_counts: got %0d/%0d want 0/0", bus.err_count, bus.sym_count); end
        n_tests++; if (bus.best_err_count !== 4'hF) begin n_fail++; $display("FAIL async_best_err: got %0h want f", bus.best_err_count); end
        drv_on = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) pat[i] = 8'h00;
        test_reset();
        test_sweep();
        test_tie();
        test_abort();
        test_locked_errors();
        test_gaps_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_search_ser.md
Name: delay_search_ser

Overview:
- Sits directly downstream of symbol_comparison and consumes its sym_correct / sym_error outputs.
- Closes the loop by driving that block's 4-bit delay_chain input.
- Sweeps all 16 delay settings, measures symbol errors over a fixed window at each, then locks on the delay with fewest errors.
- Once locked, reports the symbol error count continuously, one window at a time.

Parameters:
- WINDOW_LEN, 1024: counted symbols per measurement window; must be at least 1.
- SETTLE_LEN, 32: sym_clk_ena ticks ignored after every delay change; must be at least 1.
- CNT_W, 11: width of the symbol and error counters; must be at least clog2(WINDOW_LEN+1).

Ports:
- sys_clk  in  1  system clock, the only clock.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- sym_clk_ena  in  1  symbol-rate enable, one sys_clk wide.
- start  in  1  sampled every sys_clk; high starts or restarts the sweep.
- sym_correct  in  1  from symbol_comparison.
- sym_error  in  1  from symbol_comparison.
- delay_chain  out  4  delay select sent to symbol_comparison.
- busy  out  1  high in every state except IDLE.
- locked  out  1  high once the sweep has finished and the best delay is applied.
- best_delay  out  4  delay with the fewest errors so far.
- best_err_count  out  CNT_W  error count recorded at best_delay.
- err_count  out  CNT_W  errors in the last completed window.
- sym_count  out  CNT_W  symbols in the last completed window; always WINDOW_LEN after the first window.
- window_done  out  1  one-sys_clk pulse each time a window completes.

Behaviour:
- Reset values: delay_chain=0, busy=0, locked=0, best_delay=0, best_err_count=all ones, err_count=0, sym_count=0, window_done=0, state=IDLE. All outputs are registered.
- Counted symbol: a sys_clk cycle with sym_clk_ena=1 and (sym_correct|sym_error)=1.
  - If sym_error=1 the symbol is an error, even when sym_correct=1 at the same time.
  - If sym_clk_ena=1 but both inputs are 0, no symbol is counted.
- IDLE:
  - start=1 → SETTLE with delay_chain=0, best_err_count=all ones, best_delay=0, locked=0.
- SETTLE:
  - Counts sym_clk_ena ticks; errors are ignored.
  - After SETTLE_LEN ticks → MEASURE, with the window counters cleared.
- MEASURE:
  - Each counted symbol increments the symbol counter; error symbols also increment the error counter.
  - On the cycle the symbol counter reaches WINDOW_LEN → EVAL.
  - In that same edge, err_count and sym_count latch the final values.
  - window_done is high during the following cycle, i.e. exactly one cycle, while in EVAL.
- EVAL: lasts one cycle; no symbol counting happens in this cycle.
  - If locked=0 and the window error count < best_err_count (strict): best_err_count ← count, best_delay ← delay_chain. On a tie the lower delay is kept.
  - If locked=0 and delay_chain<15: delay_chain+1 → SETTLE.
  - If locked=0 and delay_chain=15: delay_chain ← best_delay including any update made this cycle; locked ← 1 → SETTLE.
  - If locked=1: → MEASURE directly. delay_chain is unchanged, no settle is needed, and best_* is frozen.
- start=1 in any busy state aborts the current activity. Next state is SETTLE with the same initialisation as from IDLE. Partial window counts are discarded and err_count/sym_count are unchanged.
- Asserting reset mid-window drops immediately to the reset values, asynchronously.
- Counters cannot overflow, because counting stops at WINDOW_LEN.
- The block ignores symbol_comparison pipeline latency. That latency is covered by the SETTLE_LEN requirement, SETTLE_LEN ≥ 16 + comparator latency.

Decomposition:
- Shared package ser_pkg holds:
  - the state enum {IDLE, SETTLE, MEASURE, EVAL};
  - DELAY_W=4 and NUM_DELAYS=16;
  - an all-ones init constant for best_err_count.
- Sub-module ser_window_counter: symbol and error counters with clear, enable, and a terminal-count flag.
  - It is instanced once and reused for the SETTLE tick count through a mode select.

Test Plan:
- Reset assert/deassert with start=0 → all outputs at their reset values; busy stays 0 for 100 cycles.
- WINDOW_LEN=8, SETTLE_LEN=2; stimulus model errors on every symbol except when delay_chain=5 → 16 window_done pulses during the sweep, then best_delay=5, best_err_count=0, locked=1, delay_chain=5, err_count=0 thereafter.
- Error counts equal for delays 3 and 9, all others higher → best_delay=3 (tie keeps the lower delay).
- start pulsed while in MEASURE at delay_chain=7 → next cycle state=SETTLE, delay_chain=0, best_err_count=all ones; err_count keeps its previous value.
- sym_clk_ena every 4th cycle; some enabled cycles carry sym_correct=sym_error=0; one cycle carries both high → sym_count reaches exactly WINDOW_LEN counting only valid symbols, and the both-high symbol adds 1 to err_count.
- Locked, 3 errors injected per window → window_done every WINDOW_LEN valid symbols with err_count=3; reset mid-window → immediate IDLE values.
